// File: rtl/hwag_angle_outputs_pkg.sv
// Shared constants and types for the HWAG angle-triggered output bank (package hwag_pkg).
package hwag_pkg;

    localparam int HWAG_PERIOD_720    = 7680;
    localparam int HWAG_PERIOD_360    = 3840;
    localparam int HWAG_DWELL_MAX_CLK = 1000;
    localparam int HWAG_AW            = 24;
    localparam int HWAG_DWELL_W       = 24;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } hwag_ch_state_t;

    typedef struct packed {
        logic [HWAG_AW-1:0] set;
        logic [HWAG_AW-1:0] reset;
    } hwag_window_t;

endpackage

// File: rtl/hwag_angle_outputs_if.sv
// Angle/config bundle for hwag_angle_outputs.
// HWAG_OUT_DWELL_LIMIT_EN adds the dwell_fault flags.
interface hwag_angle_outputs_if #(
    parameter int CH = 4,
    parameter int AW = 24
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic [AW-1:0] angle;
    logic          angle_step;
    logic          angle_valid;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [AW-1:0] wr_set;
    logic [AW-1:0] wr_reset;
    logic          wr_err;
    logic [CH-1:0] pending;
    logic [CH-1:0] out;
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    logic [CH-1:0] dwell_fault;
`endif

    modport master (
        output angle, angle_step, angle_valid, wr_en, wr_ch, wr_set, wr_reset,
        input  wr_err, pending, out
`ifdef HWAG_OUT_DWELL_LIMIT_EN
        , input dwell_fault
`endif
    );

    modport slave (
        input  angle, angle_step, angle_valid, wr_en, wr_ch, wr_set, wr_reset,
        output wr_err, pending, out
`ifdef HWAG_OUT_DWELL_LIMIT_EN
        , output dwell_fault
`endif
    );

endinterface

// File: rtl/hwag_angle_outputs_channel.sv
// One angle-triggered output channel: shadow/active window, OFF/ON FSM, commit logic.
// HWAG_OUT_DWELL_LIMIT_EN adds an on-time counter that forces OFF and flags a fault.
module hwag_out_channel
    import hwag_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_angle,
    input  logic          i_angle_step,
    input  logic          i_angle_valid,
    input  logic          i_wr,
    input  logic [AW-1:0] i_set,
    input  logic [AW-1:0] i_reset,
    output logic          o_out,
    output logic          o_pending
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    , output logic        o_dwell_fault
`endif
);

    hwag_ch_state_t     r_state;
    hwag_window_t       r_shadow;
    hwag_window_t       r_active;
    logic               r_pending;
    hwag_window_t       w_wr_win;
    hwag_window_t       w_win;
    logic [HWAG_AW-1:0] w_angle;
    logic               w_commit;
    logic               w_set_hit;
    logic               w_rst_hit;
    logic               w_trip;

    // A commit in this cycle is already visible to the transition compare.
    always_comb begin
        w_angle        = HWAG_AW'(i_angle);
        w_wr_win.set   = HWAG_AW'(i_set);
        w_wr_win.reset = HWAG_AW'(i_reset);
        w_commit       = r_pending && (r_state == OFF) && !i_wr &&
                         (!i_angle_valid || (i_angle_step && (w_angle == '0)));
        w_win          = w_commit ? r_shadow : r_active;
        w_set_hit      = i_angle_step && (w_angle == w_win.set) && (w_win.set != w_win.reset);
        w_rst_hit      = i_angle_step && (w_angle == w_win.reset);
    end

`ifdef HWAG_OUT_DWELL_LIMIT_EN
    logic [HWAG_DWELL_W-1:0] r_dwell;
    logic                    r_fault;

    assign w_trip = (r_state == ON) && (r_dwell == HWAG_DWELL_W'(HWAG_DWELL_MAX_CLK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
            r_fault <= 1'b0;
        end else begin
            r_dwell <= (r_state == ON) ? r_dwell + 1'b1 : '0;
            if (i_angle_valid && w_trip) begin
                r_fault <= 1'b1;
            end else if (i_wr) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign o_dwell_fault = r_fault;
`else
    assign w_trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= OFF;
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (i_wr) begin
                r_shadow  <= w_wr_win;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            if (w_commit) begin
                r_active <= r_shadow;
            end
            if (!i_angle_valid) begin
                r_state <= OFF;
            end else begin
                case (r_state)
                    OFF: if (w_set_hit) r_state <= ON;
                    ON:  if (w_rst_hit || w_trip) r_state <= OFF;
                    default: r_state <= OFF;
                endcase
            end
        end
    end

    assign o_out     = (r_state == ON);
    assign o_pending = r_pending;

endmodule

// File: rtl/hwag_angle_outputs.sv
// Bank of CH angle-triggered outputs: write decoder plus one hwag_out_channel per channel.
// HWAG_OUT_DWELL_LIMIT_EN enables per-channel dwell limiting and the dwell_fault flags.
module hwag_angle_outputs
    import hwag_pkg::*;
#(
    parameter int CH     = 4,
    parameter int AW     = 24,
    parameter int PERIOD = HWAG_PERIOD_720
) (
    input  logic                 clk,
    input  logic                 rst,
    hwag_angle_outputs_if.slave  io_bus
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic          w_wr_ok;
    logic          r_wr_err;
    logic [CH-1:0] w_out;
    logic [CH-1:0] w_pending;
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    logic [CH-1:0] w_fault;
`endif

    always_comb begin
        w_wr_ok = io_bus.wr_en &&
                  (64'(io_bus.wr_set) < 64'(PERIOD)) &&
                  (64'(io_bus.wr_reset) < 64'(PERIOD)) &&
                  (int'(io_bus.wr_ch) < CH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= io_bus.wr_en && !w_wr_ok;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic w_sel;
        assign w_sel = w_wr_ok && (io_bus.wr_ch == CW'(g));

        hwag_out_channel #(.AW(AW)) u_ch (
            .clk           (clk),
            .rst_n         (rst),
            .i_angle       (io_bus.angle),
            .i_angle_step  (io_bus.angle_step),
            .i_angle_valid (io_bus.angle_valid),
            .i_wr          (w_sel),
            .i_set         (io_bus.wr_set),
            .i_reset       (io_bus.wr_reset),
            .o_out         (w_out[g]),
            .o_pending     (w_pending[g])
`ifdef HWAG_OUT_DWELL_LIMIT_EN
            , .o_dwell_fault (w_fault[g])
`endif
        );
    end

    assign io_bus.wr_err  = r_wr_err;
    assign io_bus.out     = w_out;
    assign io_bus.pending = w_pending;
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    assign io_bus.dwell_fault = w_fault;
`endif

endmodule

// File: tb/tb_hwag_angle_outputs.sv
// Self-checking bench for hwag_angle_outputs: write table, directed angle sweeps, random traffic.
// Dwell-limit checks are compiled in with HWAG_OUT_DWELL_LIMIT_EN.
module tb_hwag_angle_outputs;
    import hwag_pkg::*;

    localparam int CH     = 4;
    localparam int AW     = 24;
    localparam int PERIOD = HWAG_PERIOD_720;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hwag_angle_outputs_if #(.CH(CH), .AW(AW)) bus ();

    hwag_angle_outputs #(.CH(CH), .AW(AW), .PERIOD(PERIOD)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    // Reference model: windows, pending flags and on/off per channel, updated per clock.
    int m_sh_set[CH];
    int m_sh_rst[CH];
    int m_ac_set[CH];
    int m_ac_rst[CH];
    bit m_pend[CH];
    bit m_on[CH];
    bit m_err;
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    int m_cnt[CH];
    bit m_fault[CH];
`endif

    typedef struct {
        bit       we;
        int       ch;
        int       ws;
        int       wr;
        bit       exp_err;
        bit [3:0] exp_pend;
    } wr_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_sh_set[c] = 0; m_sh_rst[c] = 0; m_ac_set[c] = 0; m_ac_rst[c] = 0;
            m_pend[c] = 0; m_on[c] = 0;
`ifdef HWAG_OUT_DWELL_LIMIT_EN
            m_cnt[c] = 0; m_fault[c] = 0;
`endif
        end
        m_err = 0;
    endtask

    function automatic logic [CH-1:0] pack_on();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_on[c];
        return v;
    endfunction

    function automatic logic [CH-1:0] pack_pend();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_pend[c];
        return v;
    endfunction

`ifdef HWAG_OUT_DWELL_LIMIT_EN
    function automatic logic [CH-1:0] pack_fault();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_fault[c];
        return v;
    endfunction
`endif

    task automatic model_step(input bit v, input bit s, input int a,
                              input bit we, input int ch, input int ws, input int wr);
        bit ok, is_wr, com;
        ok    = we && (ws < PERIOD) && (wr < PERIOD) && (ch < CH);
        m_err = we && !ok;
        for (int c = 0; c < CH; c++) begin
            is_wr = ok && (ch == c);
            com   = m_pend[c] && !m_on[c] && !is_wr && (!v || (s && a == 0));
            if (com) begin
                m_ac_set[c] = m_sh_set[c];
                m_ac_rst[c] = m_sh_rst[c];
                m_pend[c]   = 0;
            end
            if (is_wr) begin
                m_sh_set[c] = ws;
                m_sh_rst[c] = wr;
                m_pend[c]   = 1;
`ifdef HWAG_OUT_DWELL_LIMIT_EN
                m_fault[c]  = 0;
`endif
            end
            if (!v) begin
                m_on[c] = 0;
            end else if (m_on[c]) begin
`ifdef HWAG_OUT_DWELL_LIMIT_EN
                m_cnt[c]++;
                if (m_cnt[c] == HWAG_DWELL_MAX_CLK) begin
                    m_on[c]    = 0;
                    m_fault[c] = 1;
                end else
`endif
                if (s && a == m_ac_rst[c]) m_on[c] = 0;
            end else if (s && a == m_ac_set[c] && m_ac_set[c] != m_ac_rst[c]) begin
                m_on[c] = 1;
`ifdef HWAG_OUT_DWELL_LIMIT_EN
                m_cnt[c] = 0;
`endif
            end
        end
    endtask

    // Called just after a rising edge; drives, advances one clock, then compares.
    task automatic tick(input bit v, input bit s, input int a,
                        input bit we, input int ch, input int ws, input int wr);
        bus.angle_valid = v;
        bus.angle_step  = s;
        bus.angle       = AW'(a);
        bus.wr_en       = we;
        bus.wr_ch       = 2'(ch);
        bus.wr_set      = AW'(ws);
        bus.wr_reset    = AW'(wr);
        model_step(v, s, a, we, ch, ws, wr);
        @(posedge clk);
        #1;
        check("out", 32'(bus.out), 32'(pack_on()));
        check("pending", 32'(bus.pending), 32'(pack_pend()));
        check("wr_err", 32'(bus.wr_err), 32'(m_err));
`ifdef HWAG_OUT_DWELL_LIMIT_EN
        check("dwell_fault", 32'(bus.dwell_fault), 32'(pack_fault()));
`endif
    endtask

    task automatic sweep(input int from, input int to);
        for (int a = from; a <= to; a++) tick(1, 1, a, 0, 0, 0, 0);
    endtask

    task automatic chk_bit(input string name, input logic [CH-1:0] vec, input int c, input bit exp);
        check(name, 32'(vec[c]), 32'(exp));
    endtask

    wr_vec_t tbl[7];

    initial begin
        tbl[0] = '{1, 0, 100,      228,  0, 4'b0001};
        tbl[1] = '{1, 2, 7680,     5,    1, 4'b0001};
        tbl[2] = '{1, 3, 5,        9000, 1, 4'b0001};
        tbl[3] = '{1, 1, 7600,     50,   0, 4'b0011};
        tbl[4] = '{0, 0, 0,        0,    0, 4'b0011};
        tbl[5] = '{1, 2, 500,      500,  0, 4'b0111};
        tbl[6] = '{1, 3, 16777215, 0,    1, 4'b0111};

        rst = 1'b0;
        bus.angle_valid = 0; bus.angle_step = 0; bus.angle = '0;
        bus.wr_en = 0; bus.wr_ch = '0; bus.wr_set = '0; bus.wr_reset = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset out", 32'(bus.out), 0);
        check("reset pending", 32'(bus.pending), 0);
        check("reset wr_err", 32'(bus.wr_err), 0);
`ifdef HWAG_OUT_DWELL_LIMIT_EN
        check("reset dwell_fault", 32'(bus.dwell_fault), 0);
`endif
        rst = 1'b1;

        // Write table: no commit point (valid, no step at angle 0).
        for (int i = 0; i < 7; i++) begin
            tick(1, 0, 5, tbl[i].we, tbl[i].ch, tbl[i].ws, tbl[i].wr);
            check($sformatf("tbl%0d wr_err", i), 32'(bus.wr_err), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d pending", i), 32'(bus.pending), 32'(tbl[i].exp_pend));
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        check("commit on invalid", 32'(bus.pending), 0);

        // Revolution 0: basic and wrap windows, disabled ch2.
        sweep(0, 49);      chk_bit("wrap first rev", bus.out, 1, 0);
        sweep(50, 99);     chk_bit("basic pre", bus.out, 0, 0);
        sweep(100, 100);   chk_bit("basic set", bus.out, 0, 1);
        sweep(101, 227);   chk_bit("basic hold", bus.out, 0, 1);
        sweep(228, 228);   chk_bit("basic reset", bus.out, 0, 0);
        sweep(229, 500);   chk_bit("disabled ch2", bus.out, 2, 0);
        sweep(501, 7599);  chk_bit("wrap pre", bus.out, 1, 0);
        sweep(7600, 7600); chk_bit("wrap set", bus.out, 1, 1);
        sweep(7601, 7679); chk_bit("wrap hold", bus.out, 1, 1);

        // Revolution 1: wrap continuity, deferred commit.
        sweep(0, 0);       chk_bit("wrap no glitch", bus.out, 1, 1);
        sweep(1, 49);      chk_bit("wrap hold2", bus.out, 1, 1);
        sweep(50, 50);     chk_bit("wrap reset", bus.out, 1, 0);
        sweep(51, 150);    chk_bit("ch0 on at 150", bus.out, 0, 1);
        tick(1, 1, 151, 1, 0, 300, 400);
        chk_bit("deferred pending", bus.pending, 0, 1);
        sweep(152, 228);   chk_bit("old dwell ends", bus.out, 0, 0);
        sweep(229, 300);   chk_bit("new not yet", bus.out, 0, 0);
        sweep(301, 7679);

        // Revolution 2: new window active; loss of sync mid-dwell.
        sweep(0, 0);       chk_bit("commit at 0", bus.pending, 0, 0);
        sweep(1, 100);     chk_bit("old set ignored", bus.out, 0, 0);
        sweep(101, 300);   chk_bit("new set", bus.out, 0, 1);
        sweep(301, 350);
        tick(1, 1, 351, 1, 0, 600, 700);
        chk_bit("pend while on", bus.pending, 0, 1);
        tick(0, 0, 352, 0, 0, 0, 0);
        chk_bit("sync loss off", bus.out, 0, 0);
        chk_bit("sync loss pend", bus.pending, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk_bit("sync loss commit", bus.pending, 0, 0);
        sweep(0, 600);     chk_bit("after resync", bus.out, 0, 1);
        sweep(601, 650);
        tick(1, 1, 651, 1, 3, 10, 20);
        chk_bit("pend ch3", bus.pending, 3, 1);

        // Asynchronous reset mid-dwell.
        rst = 1'b0;
        #2;
        check("async rst out", 32'(bus.out), 0);
        check("async rst pending", 32'(bus.pending), 0);
        model_reset();
        bus.angle_valid = 0; bus.angle_step = 0; bus.wr_en = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick(0, 0, 0, 0, 0, 0, 0);
        sweep(0, 1000);
        check("post rst angles zero", 32'(bus.out), 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit v, s, we;
            int a, ch, ws, wr, sel, pc;
            v  = ($urandom % 32) != 0;
            s  = ($urandom % 3) != 0;
            we = ($urandom % 8) == 0;
            ch = $urandom_range(0, CH - 1);
            ws = (($urandom % 10) == 0) ? $urandom_range(PERIOD, PERIOD + 100) : $urandom_range(0, PERIOD - 1);
            wr = (($urandom % 10) == 0) ? $urandom_range(PERIOD, PERIOD + 100) : $urandom_range(0, PERIOD - 1);
            sel = $urandom % 6;
            pc  = $urandom_range(0, CH - 1);
            if (sel == 0)      a = 0;
            else if (sel == 1) a = m_ac_set[pc];
            else if (sel == 2) a = m_ac_rst[pc];
            else if (sel == 3) a = m_sh_set[pc] % PERIOD;
            else               a = $urandom_range(0, PERIOD - 1);
            tick(v, s, a, we, ch, ws, wr);
        end

`ifdef HWAG_OUT_DWELL_LIMIT_EN
        begin
            int high;
            high = 0;
            tick(1, 0, 5, 1, 0, 10, 20);
            tick(0, 0, 0, 0, 0, 0, 0);
            tick(1, 1, 10, 0, 0, 0, 0);
            chk_bit("dwell on", bus.out, 0, 1);
            for (int i = 0; i < HWAG_DWELL_MAX_CLK + 10; i++) begin
                tick(1, 0, 15, 0, 0, 0, 0);
                if (bus.out[0]) high++;
            end
            check("dwell length", 32'(high), 32'(HWAG_DWELL_MAX_CLK - 1));
            chk_bit("dwell fault set", bus.dwell_fault, 0, 1);
            tick(1, 1, 20, 0, 0, 0, 0);
            chk_bit("dwell reset ignored", bus.out, 0, 0);
            tick(1, 0, 5, 1, 0, 10, 20);
            chk_bit("dwell fault cleared", bus.dwell_fault, 0, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
